// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: immediate classes,
// fetch FSM states and the opcode encodings the immediate generator decodes.
package fetch_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_SB   = 3'd3,
        IMM_U    = 3'd4
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    // bne uses its own major opcode in this ISA variant, not a func3 of BEQ
    localparam logic [6:0] OP_BNE   = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/grant/rvalid channel between fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_unit_if #(
    parameter int XLEN = 64
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/instr_fetch_unit_imm_gen.sv
// Combinational immediate generator: classifies the instruction word by opcode
// and produces the sign-extended immediate the capture registers load.
module imm_gen
    import fetch_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     ir,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type
);

    always_comb begin
        imm      = '0;
        imm_type = IMM_NONE;
        case (ir[6:0])
            OP_LD, OP_ADDI: begin
                imm      = {{(XLEN-12){ir[31]}}, ir[31:20]};
                imm_type = IMM_I;
            end
            OP_SD: begin
                imm      = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
                imm_type = IMM_S;
            end
            OP_BEQ, OP_BNE: begin
                imm      = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                imm_type = IMM_SB;
            end
            OP_LUI: begin
                imm      = {{(XLEN-32){ir[31]}}, ir[31:12], 12'b0};
                imm_type = IMM_U;
            end
            OP_RTYPE: begin
                imm      = '0;
                imm_type = IMM_NONE;
            end
            default: begin
                imm      = '0;
                imm_type = IMM_NONE;
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage: one word request per fetch_start, captured
// into the instruction register with decoded fields. Optional FETCH_TIMEOUT_EN.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no fetch in flight; accepts fetch_start
//   REQ     | imem_req high with stable address until imem_gnt
//   WAIT    | granted, waiting for imem_rvalid
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_start,
    input  logic [XLEN-1:0]     pc,
    instr_fetch_unit_if.master  imem,
    output logic                fetch_busy,
    output logic                ir_valid,
    output logic [31:0]         instr,
    output logic [6:0]          opcode,
    output logic [2:0]          func3,
    output logic [6:0]          func7,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [XLEN-1:0]     imm,
    output imm_type_e           imm_type,
    output logic                fetch_err
);

    localparam logic [XLEN-1:0] ADDR_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

    fetch_state_e    state_q, state_d;
    logic            accept;
    logic            capture;
    logic [XLEN-1:0] addr_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] imm_q;
    imm_type_e       imm_type_q;
    logic            ir_valid_q;
    logic [XLEN-1:0] imm_d;
    imm_type_e       imm_type_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          timeout;
    logic          fetch_err_q;

    // Down-counter: loaded on accept, terminal count in the last allowed cycle
    assign timeout = (state_q != ST_IDLE) && !capture && (tmo_cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q   <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= timeout;
            if (accept)
                tmo_cnt_q <= TW'(TIMEOUT_CYCLES - 1);
            else if (state_q != ST_IDLE && tmo_cnt_q != '0)
                tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_start) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem.gnt) begin
                    if (imem.rvalid) begin
                        capture = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem.rvalid) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef FETCH_TIMEOUT_EN
        if (timeout)
            state_d = ST_IDLE;
`endif
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .ir       (imem.rdata),
        .imm      (imm_d),
        .imm_type (imm_type_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            instr_q    <= '0;
            imm_q      <= '0;
            imm_type_q <= IMM_NONE;
            ir_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= pc & ADDR_MASK;
                ir_valid_q <= 1'b0;
            end
            if (capture) begin
                instr_q    <= imem.rdata;
                imm_q      <= imm_d;
                imm_type_q <= imm_type_d;
                ir_valid_q <= 1'b1;
            end
        end
    end

    // All outputs come straight from state or capture registers
    assign imem.req   = (state_q == ST_REQ);
    assign imem.addr  = addr_q;
    assign fetch_busy = (state_q != ST_IDLE);
    assign ir_valid   = ir_valid_q;
    assign instr      = instr_q;
    assign opcode     = instr_q[6:0];
    assign func3      = instr_q[14:12];
    assign func7      = instr_q[31:25];
    assign rs1        = instr_q[19:15];
    assign rs2        = instr_q[24:20];
    assign rd         = instr_q[11:7];
    assign imm        = imm_q;
    assign imm_type   = imm_type_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table of fetches with memory
// timing, plus reset, busy/misaligned, back-to-back and timeout sequences.
module tb_instr_fetch_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            fetch_start;
    logic [XLEN-1:0] pc;
    logic            fetch_busy;
    logic            ir_valid;
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic            fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit_if #(.XLEN(XLEN)) imem ();

    instr_fetch_unit #(.XLEN(XLEN), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc          (pc),
        .imem        (imem),
        .fetch_busy  (fetch_busy),
        .ir_valid    (ir_valid),
        .instr       (instr),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .imm         (imm),
        .imm_type    (imm_type),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
        int          gd;
        int          rd;
        bit          noise;
        logic [63:0] addr;
        logic [63:0] imm;
        logic [2:0]  ityp;
        logic [6:0]  op;
        logic [4:0]  rd_f;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int reqc;
        int k;
        int addr_bad;
        string tag;
        tag = $sformatf("v%0d", idx);
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        fetch_start = 1'b1;
        pc          = v.pc;
        tick();
        fetch_start = 1'b0;
        pc          = 64'hBAD0;
        chk({tag, "_ir_valid_fall"}, 64'(ir_valid), 64'd0);
        lat = 1; reqc = 0; k = 0; addr_bad = 0;
        while (!ir_valid && lat < 64) begin
            if (imem.req) begin
                reqc++;
                if (imem.addr !== v.addr) addr_bad++;
            end
            imem.gnt    = (k == v.gd) || (v.noise && k > v.gd);
            imem.rvalid = (k == v.gd + v.rd) || (v.noise && k < v.gd);
            imem.rdata  = (k == v.gd + v.rd) ? v.data : (32'hDEAD_BEEF ^ 32'(k));
            tick();
            k++;
            lat++;
        end
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        chk({tag, "_latency"},   64'(lat),  64'(v.gd + v.rd + 2));
        chk({tag, "_req_cycles"}, 64'(reqc), 64'(v.gd + 1));
        chk({tag, "_addr_stable"}, 64'(addr_bad), 64'd0);
        chk({tag, "_addr"},      imem.addr, v.addr);
        chk({tag, "_ir_valid"},  64'(ir_valid), 64'd1);
        chk({tag, "_busy"},      64'(fetch_busy), 64'd0);
        chk({tag, "_instr"},     64'(instr), 64'(v.data));
        chk({tag, "_opcode"},    64'(opcode), 64'(v.op));
        chk({tag, "_rd"},        64'(rd), 64'(v.rd_f));
        chk({tag, "_rs1"},       64'(rs1), 64'(v.rs1));
        chk({tag, "_rs2"},       64'(rs2), 64'(v.rs2));
        chk({tag, "_func3"},     64'(func3), 64'(v.f3));
        chk({tag, "_func7"},     64'(func7), 64'(v.f7));
        chk({tag, "_imm"},       imm, v.imm);
        chk({tag, "_imm_type"},  64'(imm_type), 64'(v.ityp));
        chk({tag, "_fetch_err"}, 64'(fetch_err), 64'd0);
    endtask

    initial begin
        int k;
        bit err_seen;

        //           pc                     data          gd rd noise addr                   imm                    typ   op        rd  rs1 rs2 f3 f7
        vecs[0] = '{64'h10,                32'hFFF30313, 0, 0, 1'b0, 64'h10,                64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 7'h13, 5'd6,  5'd6,  5'd31, 3'd0, 7'h7F};
        vecs[1] = '{64'h20,                32'h00B50463, 3, 2, 1'b1, 64'h20,                64'h8,                   3'd3, 7'h63, 5'd8,  5'd10, 5'd11, 3'd0, 7'h00};
        vecs[2] = '{64'h1000,              32'h123452B7, 1, 0, 1'b0, 64'h1000,              64'h1234_5000,           3'd4, 7'h37, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09};
        vecs[3] = '{64'h44,                32'h40B50533, 0, 1, 1'b0, 64'h44,                64'h0,                   3'd0, 7'h33, 5'd10, 5'd10, 5'd11, 3'd0, 7'h20};
        vecs[4] = '{64'h7,                 32'hFE113C23, 2, 0, 1'b1, 64'h4,                 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 7'h23, 5'd24, 5'd2,  5'd1,  3'd3, 7'h7F};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFE, 32'hFE209EE7, 0, 3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 7'h67, 5'd29, 5'd1,  5'd2,  3'd1, 7'h7F};
        vecs[6] = '{64'h2000,              32'h0085B503, 0, 0, 1'b0, 64'h2000,              64'h8,                   3'd1, 7'h03, 5'd10, 5'd11, 5'd8,  3'd3, 7'h00};

        reset       = 1'b1;
        fetch_start = 1'b0;
        pc          = '0;
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_req",      64'(imem.req), 64'd0);
        chk("rst_addr",     imem.addr, 64'd0);
        chk("rst_busy",     64'(fetch_busy), 64'd0);
        chk("rst_ir_valid", 64'(ir_valid), 64'd0);
        chk("rst_instr",    64'(instr), 64'd0);
        chk("rst_imm",      imm, 64'd0);
        chk("rst_imm_type", 64'(imm_type), 64'd0);
        chk("rst_fetch_err", 64'(fetch_err), 64'd0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Busy + misaligned: second pulse while busy must not be taken
        fetch_start = 1'b1;
        pc          = 64'h13;
        tick();
        pc = 64'h80;
        tick();
        fetch_start = 1'b0;
        chk("busy_addr", imem.addr, 64'h10);
        chk("busy_req",  64'(imem.req), 64'd1);
        imem.gnt    = 1'b1;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h123452B7;
        tick();
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        chk("busy_ir_valid", 64'(ir_valid), 64'd1);
        chk("busy_instr",    64'(instr), 64'h123452B7);
        tick();
        chk("busy_no_refetch", 64'(fetch_busy), 64'd0);

        // Back-to-back: new fetch accepted in the cycle ir_valid rises
        fetch_start = 1'b1;
        pc          = 64'h300;
        tick();
        fetch_start = 1'b0;
        imem.gnt    = 1'b1;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h40B50533;
        tick();
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        chk("b2b_first_valid", 64'(ir_valid), 64'd1);
        fetch_start = 1'b1;
        pc          = 64'h404;
        tick();
        fetch_start = 1'b0;
        chk("b2b_ir_valid_fall", 64'(ir_valid), 64'd0);
        chk("b2b_req",           64'(imem.req), 64'd1);
        chk("b2b_addr",          imem.addr, 64'h404);
        imem.gnt    = 1'b1;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hFFF30313;
        tick();
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        chk("b2b_second_instr", 64'(instr), 64'hFFF30313);
        chk("b2b_second_imm",   imm, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset during REQ, late rvalid afterwards must be ignored
        fetch_start = 1'b1;
        pc          = 64'h40;
        tick();
        fetch_start = 1'b0;
        chk("mid_rst_req_before", 64'(imem.req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_req",      64'(imem.req), 64'd0);
        chk("mid_rst_addr",     imem.addr, 64'd0);
        chk("mid_rst_busy",     64'(fetch_busy), 64'd0);
        chk("mid_rst_ir_valid", 64'(ir_valid), 64'd0);
        chk("mid_rst_instr",    64'(instr), 64'd0);
        tick();
        reset       = 1'b0;
        imem.gnt    = 1'b1;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h00B50463;
        tick();
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        chk("late_rv_ir_valid", 64'(ir_valid), 64'd0);
        chk("late_rv_instr",    64'(instr), 64'd0);
        chk("late_rv_busy",     64'(fetch_busy), 64'd0);
        chk("late_rv_imm",      imm, 64'd0);
        chk("late_rv_imm_type", 64'(imm_type), 64'd0);
        chk("late_rv_rd",       64'(rd), 64'd0);

        // Give the instruction register a known value before the no-grant test
        run_vec(2, vecs[2]);

        fetch_start = 1'b1;
        pc          = 64'h500;
        tick();
        fetch_start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        k = 1;
        while (!fetch_err && k < 40) begin
            tick();
            k++;
        end
        chk("tmo_cycle",    64'(k), 64'd17);
        chk("tmo_busy",     64'(fetch_busy), 64'd0);
        chk("tmo_req",      64'(imem.req), 64'd0);
        chk("tmo_ir_valid", 64'(ir_valid), 64'd0);
        chk("tmo_instr",    64'(instr), 64'h123452B7);
        tick();
        chk("tmo_pulse_width", 64'(fetch_err), 64'd0);
`else
        err_seen = 1'b0;
        for (k = 0; k < 20; k++) begin
            if (fetch_err) err_seen = 1'b1;
            tick();
        end
        chk("no_tmo_err",  64'(err_seen), 64'd0);
        chk("no_tmo_req",  64'(imem.req), 64'd1);
        chk("no_tmo_busy", 64'(fetch_busy), 64'd1);
        imem.gnt    = 1'b1;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h0085B503;
        tick();
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        chk("no_tmo_capture", 64'(instr), 64'h0085B503);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
